// File: rtl/pwm_call_arbiter.sv
// ---------------------------------------------------------------------------
// pwm_call_arbiter
//   Two-requester round-robin arbiter in front of a single shared PWM method
//   port. A granted requester's two argument words are latched onto
//   out_a/out_b, a one-cycle out_req strobe is issued, and the call is then
//   tracked through the port's out_busy handshake (rise = acknowledge,
//   fall = completion). A missing acknowledge is bounded by ACK_TIMEOUT.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous reset, active low
//   a_req/b_req      call request level per requester
//   a_arg0/a_arg1,   argument words, held stable while x_req is high
//   b_arg0/b_arg1
//   a_busy/b_busy    call accepted and in progress (never both high)
//   a_done/b_done    one-cycle pulse when that requester's call ends
//   out_a/out_b      latched arguments presented to the shared port
//   out_req          one-cycle call strobe to the shared port
//   out_busy         shared port busy/acknowledge
//   err              sticky acknowledge-timeout flag
//   err_clr          synchronous clear of err (a same-cycle timeout wins)
//   call_count       calls completed without timeout, wraps at 16 bits
// ---------------------------------------------------------------------------
module pwm_call_arbiter #(
   parameter int WIDTH       = 32,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_req,
   input  logic [WIDTH-1:0] a_arg0,
   input  logic [WIDTH-1:0] a_arg1,
   output logic             a_busy,
   output logic             a_done,
   input  logic             b_req,
   input  logic [WIDTH-1:0] b_arg0,
   input  logic [WIDTH-1:0] b_arg1,
   output logic             b_busy,
   output logic             b_done,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_req,
   input  logic             out_busy,
   output logic             err,
   input  logic             err_clr,
   output logic [15:0]      call_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, ACK, RUN} state_t;

   // Timer expires on the last permitted ACK cycle, so exactly ACK_TIMEOUT
   // cycles are spent in ACK before the call is abandoned.
   localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic       last_grant;     // 0 = A granted last, 1 = B granted last
   logic [7:0] ack_cnt;

   logic a_pend, b_pend;
   logic grant_a, grant_b, do_grant;
   logic ack_expire, run_end, call_end;

   // A requester already in a call is never pending, so x_req activity
   // during its own call has no effect.
   assign a_pend   = a_req & ~a_busy;
   assign b_pend   = b_req & ~b_busy;

   // On a tie the requester not served last wins.
   assign grant_a  = a_pend & (~b_pend | last_grant);
   assign grant_b  = b_pend & (~a_pend | ~last_grant);
   assign do_grant = (state == IDLE) & (grant_a | grant_b);

   assign ack_expire = (state == ACK) & ~out_busy & (ack_cnt == ACK_LAST);
   assign run_end    = (state == RUN) & ~out_busy;
   assign call_end   = run_end | ack_expire;

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_a | grant_b) state_nxt = ISSUE;
         // An acknowledge already present during the strobe skips ACK.
         ISSUE:   state_nxt = out_busy ? RUN : ACK;
         ACK: begin
            if (out_busy)        state_nxt = RUN;
            else if (ack_expire) state_nxt = IDLE;
         end
         RUN:     if (!out_busy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- grant, argument latch, strobe ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant <= 1'b1;
         out_a      <= '0;
         out_b      <= '0;
         out_req    <= 1'b0;
      end else begin
         out_req <= do_grant;
         if (do_grant) begin
            last_grant <= grant_b;
            out_a      <= grant_b ? b_arg0 : a_arg0;
            out_b      <= grant_b ? b_arg1 : a_arg1;
         end
      end
   end

   // ---------------- per-requester busy / done ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_busy <= 1'b0;
         b_busy <= 1'b0;
         a_done <= 1'b0;
         b_done <= 1'b0;
      end else begin
         a_done <= call_end & a_busy;
         b_done <= call_end & b_busy;
         if (do_grant) begin
            a_busy <= grant_a;
            b_busy <= grant_b;
         end else if (call_end) begin
            a_busy <= 1'b0;
            b_busy <= 1'b0;
         end
      end
   end

   // ---------------- acknowledge timer ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ack_cnt <= '0;
      else if ((state == ACK) && !out_busy && !ack_expire)
         ack_cnt <= ack_cnt + 8'd1;
      else
         ack_cnt <= '0;
   end

   // ---------------- error flag and completion counter ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err        <= 1'b0;
         call_count <= '0;
      end else begin
         if (ack_expire)   err <= 1'b1;
         else if (err_clr) err <= 1'b0;
         // Natural 16-bit wrap from FFFF to 0.
         if (run_end) call_count <= call_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pwm_call_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pwm_call_arbiter
//   Directed stimulus pushes expected out_req / done events into a queue; a
//   monitor on the falling clock edge pops and compares whenever the DUT
//   strobes out_req or a done pulse.
// ---------------------------------------------------------------------------
module tb_pwm_call_arbiter;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          a_req = 1'b0, b_req = 1'b0;
   logic [W-1:0]  a_arg0 = '0, a_arg1 = '0, b_arg0 = '0, b_arg1 = '0;
   logic          a_busy, a_done, b_busy, b_done;
   logic [W-1:0]  out_a, out_b;
   logic          out_req;
   logic          out_busy = 1'b0;
   logic          err;
   logic          err_clr = 1'b0;
   logic [15:0]   call_count;

   pwm_call_arbiter #(.WIDTH(W), .ACK_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_arg0(a_arg0), .a_arg1(a_arg1), .a_busy(a_busy), .a_done(a_done),
      .b_req(b_req), .b_arg0(b_arg0), .b_arg1(b_arg1), .b_busy(b_busy), .b_done(b_done),
      .out_a(out_a), .out_b(out_b), .out_req(out_req), .out_busy(out_busy),
      .err(err), .err_clr(err_clr), .call_count(call_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           done;
      bit           who;   // 0 = A, 1 = B
      logic [W-1:0] a, b;
      logic [15:0]  cnt;
      logic         err;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         mev;
   int          n_chk = 0, n_fail = 0;
   logic [15:0] exp_cnt = '0;
   int          cyc = 0, last_req = -100;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s (no expected event queued)", name);
   endtask

   function automatic void push_req(input bit who, input logic [W-1:0] a, input logic [W-1:0] b);
      ev_t e;
      e.done = 1'b0; e.who = who; e.a = a; e.b = b; e.cnt = '0; e.err = 1'b0;
      exp_q.push_back(e);
   endfunction

   function automatic void push_done(input bit who, input logic [15:0] cnt, input logic e_err);
      ev_t e;
      e.done = 1'b1; e.who = who; e.a = '0; e.b = '0; e.cnt = cnt; e.err = e_err;
      exp_q.push_back(e);
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      cyc++;
      if (!reset) last_req = -100;
      else begin
         if (a_busy || b_busy) check("busy_exclusive", a_busy & b_busy, 0);
         if (out_req) begin
            if (last_req >= 0) check("req_gap_ge3", (cyc - last_req) >= 3, 1);
            last_req = cyc;
            if (exp_q.size() == 0) fail_now("unexpected_out_req");
            else begin
               mev = exp_q.pop_front();
               check("event_is_req", 0, mev.done);
               check("req_grantee_b", b_busy, mev.who);
               check("req_grantee_a", a_busy, !mev.who);
               check("req_out_a", out_a, mev.a);
               check("req_out_b", out_b, mev.b);
            end
         end
         if (a_done || b_done) begin
            if (exp_q.size() == 0) fail_now("unexpected_done");
            else begin
               mev = exp_q.pop_front();
               check("event_is_done", 1, mev.done);
               check("done_is_b", b_done, mev.who);
               check("done_is_a", a_done, !mev.who);
               check("done_call_count", call_count, mev.cnt);
               check("done_err", err, mev.err);
               check("done_busy_clear", a_busy | b_busy, 0);
            end
         end
      end
   end

   task automatic tick;
      @(negedge clk);
   endtask

   // Returns on the falling edge of the cycle in which out_req is high.
   task automatic wait_req;
      int n = 0;
      do begin
         tick;
         n++;
      end while (!out_req && n < 30);
      if (!out_req) check("wait_out_req_timeout", 0, 1);
   endtask

   // fast: raise out_busy during the strobe cycle; otherwise one cycle later.
   task automatic serve(input bit fast, input int run_len, input bit drop);
      wait_req;
      if (drop) begin a_req = 1'b0; b_req = 1'b0; end
      if (!fast) tick;
      out_busy = 1'b1;
      repeat (run_len) tick;
      out_busy = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      // ---------------- reset state ----------------
      repeat (3) tick;
      check("rst_a_busy", a_busy, 0);
      check("rst_b_busy", b_busy, 0);
      check("rst_a_done", a_done, 0);
      check("rst_b_done", b_done, 0);
      check("rst_out_req", out_req, 0);
      check("rst_out_a", out_a, 0);
      check("rst_out_b", out_b, 0);
      check("rst_err", err, 0);
      check("rst_call_count", call_count, 0);
      reset = 1'b1;
      tick;

      // ---------------- tie after reset: A, B, A, B ----------------
      a_arg0 = 32'd11; a_arg1 = 32'd22; b_arg0 = 32'd33; b_arg1 = 32'd44;
      for (int i = 0; i < 4; i++) begin
         push_req(i[0], i[0] ? 32'd33 : 32'd11, i[0] ? 32'd44 : 32'd22);
         exp_cnt++;
         push_done(i[0], exp_cnt, 1'b0);
      end
      a_req = 1'b1; b_req = 1'b1;
      repeat (4) serve(1'b1, 1, 1'b0);
      tick;
      a_req = 1'b0; b_req = 1'b0;
      repeat (3) tick;

      // ---------------- single call, normal acknowledge ----------------
      a_arg0 = 32'd5; a_arg1 = 32'd9;
      push_req(1'b0, 32'd5, 32'd9);
      exp_cnt++;
      push_done(1'b0, exp_cnt, 1'b0);
      a_req = 1'b1;
      serve(1'b0, 4, 1'b1);
      repeat (4) tick;
      check("hold_out_a", out_a, 32'd5);
      check("hold_out_b", out_b, 32'd9);
      check("count_after_single", call_count, 16'd5);

      // ---------------- acknowledge timeout ----------------
      a_arg0 = 32'd7; a_arg1 = 32'd8;
      push_req(1'b0, 32'd7, 32'd8);
      push_done(1'b0, exp_cnt, 1'b1);
      a_req = 1'b1;
      wait_req;
      a_req = 1'b0;
      repeat (8) tick;
      check("timeout_err_set", err, 1);
      check("timeout_count_unchanged", call_count, 16'd5);
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      check("err_cleared", err, 0);

      // ---------------- timeout while err_clr held: set wins ----------------
      b_arg0 = 32'hA; b_arg1 = 32'hB;
      push_req(1'b1, 32'hA, 32'hB);
      push_done(1'b1, exp_cnt, 1'b1);
      err_clr = 1'b1;
      b_req = 1'b1;
      wait_req;
      b_req = 1'b0;
      repeat (5) tick;           // done cycle: monitor sees err=1
      tick;
      check("err_clr_after_set", err, 0);
      err_clr = 1'b0;
      repeat (2) tick;

      // ---------------- fast acknowledge skips ACK ----------------
      a_arg0 = 32'h1234; a_arg1 = 32'h5678;
      push_req(1'b0, 32'h1234, 32'h5678);
      exp_cnt++;
      push_done(1'b0, exp_cnt, 1'b0);
      a_req = 1'b1;
      serve(1'b1, 1, 1'b1);
      repeat (4) tick;
      check("fast_no_err", err, 0);

      // ---------------- call_count wrap ----------------
      force dut.call_count = 16'hFFFF;
      tick;
      release dut.call_count;
      tick;
      check("preload_count", call_count, 16'hFFFF);
      exp_cnt = 16'hFFFF;
      b_arg0 = 32'hDEAD; b_arg1 = 32'hBEEF;
      push_req(1'b1, 32'hDEAD, 32'hBEEF);
      exp_cnt++;
      push_done(1'b1, exp_cnt, 1'b0);
      b_req = 1'b1;
      serve(1'b0, 2, 1'b1);
      repeat (4) tick;
      check("wrap_count", call_count, 16'd0);

      // ---------------- reset during RUN ----------------
      a_arg0 = 32'h77; a_arg1 = 32'h88;
      push_req(1'b0, 32'h77, 32'h88);
      a_req = 1'b1;
      wait_req;
      a_req = 1'b0;
      tick;
      out_busy = 1'b1;
      repeat (2) tick;           // now in RUN
      reset = 1'b0;
      #1;
      check("midrst_a_busy", a_busy, 0);
      check("midrst_a_done", a_done, 0);
      check("midrst_out_req", out_req, 0);
      check("midrst_out_a", out_a, 0);
      check("midrst_out_b", out_b, 0);
      out_busy = 1'b0;
      repeat (2) tick;
      reset = 1'b1;
      exp_cnt = '0;
      tick;
      a_arg0 = 32'h99; a_arg1 = 32'hAA;
      push_req(1'b0, 32'h99, 32'hAA);
      exp_cnt++;
      push_done(1'b0, exp_cnt, 1'b0);
      a_req = 1'b1;
      tick;
      check("post_rst_out_req", out_req, 1);
      check("post_rst_a_busy", a_busy, 1);
      a_req = 1'b0;
      tick;
      out_busy = 1'b1;
      repeat (2) tick;
      out_busy = 1'b0;
      repeat (4) tick;
      check("post_rst_count", call_count, 16'd1);

      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
